fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage sitting between program_counter and the IF/ID boundary of the 5-stage RISC-V core.
- Issues instruction-memory requests at the current PC through a valid/ready handshake and tracks outstanding requests.
- Pairs in-order responses with their PCs in a small circular buffer and presents {pc, instr} to decode with a valid/ready handshake.
- Drives the PC enable (stall) and discards in-flight fetches on a redirect (flush).

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- DATA_WIDTH, 32, instruction width.
- MAX_OUTSTANDING, 3, buffer depth; also the maximum number of allocated entries (requested, unfilled or unconsumed). Must be ≥2. A value of 3 gives 1 instr/cycle at memory latency 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  ADDR_WIDTH  current PC from program_counter.
- pc_en  out  1  enable to program_counter; advances the PC.
- flush  in  1  redirect; asserted in the same cycle as the PC's jump_en.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  equals {pc_in[ADDR_WIDTH-1:2], 2'b00}.
- imem_rsp_valid  in  1  response valid; in order, exactly one per accepted request, latency ≥1, no backpressure.
- imem_rsp_data  in  DATA_WIDTH  instruction.
- id_valid  out  1  decode entry valid.
- id_ready  in  1  decode accepts.
- id_pc  out  ADDR_WIDTH  PC of the presented instruction.
- id_instr  out  DATA_WIDTH  instruction; NOP_INSTR when id_valid=0.

Behaviour:
- Clocking and reset: single clk; rst is asynchronous, active-high.
- Reset values: buffer empty; all pointers, counters and drop_cnt = 0; imem_req_valid=0; pc_en=0; id_valid=0; id_pc=0; id_instr=NOP_INSTR.
- Allocation: alloc_cnt = number of allocated entries.
  - imem_req_valid = !flush && (alloc_cnt < MAX_OUTSTANDING).
  - A request is accepted on imem_req_valid && imem_req_ready. Acceptance allocates the tail entry {pc=pc_in, filled=0}.
  - pc_en = accept || flush. The PC advances by 4 only on acceptance and loads its jump target during flush.
- Fill: on imem_rsp_valid with drop_cnt==0, write imem_rsp_data into the oldest unfilled entry and set filled=1.
  - An unexpected response (no unfilled entry and drop_cnt==0) is ignored.
- Output: the head entry is registered state. id_valid = head.filled; id_pc/id_instr come from the head.
  - Pop on id_valid && id_ready; the next entry appears the following cycle.
- Latency: request accepted in cycle N, response in cycle N+L, id_valid in cycle N+L+1.
- Credit check: the check does not see a same-cycle pop, so there is no combinational id_ready→imem_req_valid path.
- Simultaneous allocation, fill and pop in one cycle are all legal. alloc_cnt_next = alloc_cnt + accept − pop.
- Full: at alloc_cnt==MAX_OUTSTANDING, req_valid=0 and pc_en=0, so the PC holds.
- Empty: id_valid=0 and id_instr=NOP_INSTR.
- Pointer wrap: modulo MAX_OUTSTANDING; the depth need not be a power of 2. Counters use $clog2(MAX_OUTSTANDING+1) bits.
- Flush cycle:
  - No request is issued.
  - The buffer is cleared at the next edge. Any id handshake in this cycle is void, because decode flushes too.
  - drop_cnt_next = drop_cnt + unfilled_allocated − imem_rsp_valid.
  - Responses arriving while drop_cnt>0 are discarded and decrement drop_cnt.
- Request issue after flush: requests resume the cycle after flush, at the target PC. They allocate normally even while drop_cnt>0.
- Back-to-back flushes accumulate drop_cnt under the same formula.
- Reset mid-operation: immediate return to reset values. In-flight responses after rst deasserts are the memory's responsibility; the memory is reset together with this block.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With the macro defined:
  - Adds outputs perf_fetched (32 bit, increments per pop) and perf_dropped (32 bit, increments per discarded response and per filled entry cleared by flush).
  - Both counters reset to 0 and wrap at 2^32.
- Without the macro: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- fetch_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - fetch_entry_t struct {pc, instr, filled}.
  - Default MAX_OUTSTANDING.
- One sub-module, fetch_buffer: circular buffer with alloc/fill/pop/clear ports, pointer and count logic.
- Handshake logic, pc_en and drop_cnt stay in fetch_stage.

Test Plan:
- Reset: rst=1 for 2 cycles, then release, with pc_in=0, req_ready=1 and 1-cycle memory → req_addr 0,4,8 on consecutive cycles; id_valid first high 2 cycles after the first accept, presenting pc 0x0, then 0x4, 0x8 every cycle.
- Backpressure: id_ready=0 from the first id_valid → exactly 3 requests accepted, then pc_en=0 and req_valid=0; id_ready=1 → id pc/instr stream resumes in order with no loss or duplication.
- Memory stall: req_ready=0 for 3 cycles → pc_en=0 and pc_in held; addresses resume without a gap.
- Flush with 2 in flight: memory latency 3, flush with target 0xCAFE_BAB8 → the 2 stale responses are discarded; first id_pc=0xCAFE_BAB8, then 0xCAFE_BABC.
- Flush coincident with a response, and back-to-back flushes → drop_cnt per the formula; no stale PC reaches decode.
- Misaligned pc_in=0xCAFE_BABE → req_addr=0xCAFE_BABC and id_pc=0xCAFE_BABE.
- With FETCH_PERF_EN defined → perf_fetched equals the number of pops and perf_dropped equals the number of stale entries (2 in the flush scenario).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN            = 32;
  localparam int unsigned FETCH_MAX_OUTSTANDING = 3;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
    logic                  filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Circular buffer pairing fetch PCs with in-order memory responses; the head entry is
// presented to decode. Depth need not be a power of two.
module fetch_buffer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  alloc_i,
  input  logic [ADDR_WIDTH-1:0] alloc_pc_i,
  input  logic                  fill_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  input  logic                  pop_i,
  output logic                  head_valid_o,
  output logic [ADDR_WIDTH-1:0] head_pc_o,
  output logic [DATA_WIDTH-1:0] head_instr_o,
  output logic [CNT_W-1:0]      alloc_cnt_o,
  output logic [CNT_W-1:0]      unfilled_cnt_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]       head_q, tail_q, fill_ptr_q;
  logic [CNT_W-1:0]      alloc_cnt_q, unfilled_cnt_q;
  logic [DEPTH-1:0]      filled_q;
  logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_q [DEPTH];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // alloc, fill and pop always touch distinct entries, so the filled bits never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      fill_ptr_q     <= '0;
      alloc_cnt_q    <= '0;
      unfilled_cnt_q <= '0;
      filled_q       <= '0;
    end else if (clear_i) begin
      head_q         <= '0;
      tail_q         <= '0;
      fill_ptr_q     <= '0;
      alloc_cnt_q    <= '0;
      unfilled_cnt_q <= '0;
      filled_q       <= '0;
    end else begin
      if (alloc_i) begin
        filled_q[tail_q] <= 1'b0;
        tail_q           <= ptr_inc(tail_q);
      end
      if (fill_i) begin
        filled_q[fill_ptr_q] <= 1'b1;
        fill_ptr_q           <= ptr_inc(fill_ptr_q);
      end
      if (pop_i) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= ptr_inc(head_q);
      end
      alloc_cnt_q    <= alloc_cnt_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
      unfilled_cnt_q <= unfilled_cnt_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_i && !clear_i) pc_q[tail_q] <= alloc_pc_i;
    if (fill_i && !clear_i)  instr_q[fill_ptr_q] <= fill_data_i;
  end

  assign head_valid_o   = filled_q[head_q];
  assign head_pc_o      = pc_q[head_q];
  assign head_instr_o   = instr_q[head_q];
  assign alloc_cnt_o    = alloc_cnt_q;
  assign unfilled_cnt_o = unfilled_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues imem requests at the PC, pairs responses with PCs and feeds
// decode; drops stale responses after a redirect. FETCH_PERF_EN adds perf counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_en,
  input  logic                  flush,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_dropped
`endif
);

  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
  // Repeated redirects can leave more stale responses in flight than the buffer depth.
  localparam int unsigned DropW = CntW + 4;

  logic [CntW-1:0]       alloc_cnt, unfilled_cnt;
  logic                  head_valid;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_instr;
  logic                  accept, fill, pop, rsp_expected;
  logic [DropW-1:0]      drop_q, drop_d;

  // Credit check ignores a same-cycle pop so id_ready never reaches imem_req_valid.
  assign imem_req_valid = !rst && !flush && (alloc_cnt < CntW'(MAX_OUTSTANDING));
  assign imem_req_addr  = {pc_in[ADDR_WIDTH-1:2], 2'b00};
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_en          = !rst && (accept || flush);

  assign id_valid = head_valid;
  assign id_pc    = head_valid ? head_pc : '0;
  assign id_instr = head_valid ? head_instr : DATA_WIDTH'(NOP_INSTR);
  assign pop      = id_valid && id_ready && !flush;

  assign rsp_expected = imem_rsp_valid && ((drop_q != '0) || (unfilled_cnt != '0));
  assign fill         = imem_rsp_valid && (drop_q == '0) && (unfilled_cnt != '0) && !flush;

  always_comb begin
    drop_d = drop_q;
    if (flush) begin
      drop_d = drop_q + DropW'(unfilled_cnt) - DropW'(rsp_expected);
    end else if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  fetch_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_OUTSTANDING),
    .CNT_W      (CntW)
  ) u_buffer (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (flush),
    .alloc_i        (accept),
    .alloc_pc_i     (pc_in),
    .fill_i         (fill),
    .fill_data_i    (imem_rsp_data),
    .pop_i          (pop),
    .head_valid_o   (head_valid),
    .head_pc_o      (head_pc),
    .head_instr_o   (head_instr),
    .alloc_cnt_o    (alloc_cnt),
    .unfilled_cnt_o (unfilled_cnt)
  );

`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetched_q, perf_dropped_q;
  logic [CntW-1:0] filled_cnt;

  assign filled_cnt = alloc_cnt - unfilled_cnt;

  // On a redirect every filled entry plus any response landing that cycle is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (pop) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (flush) begin
        perf_dropped_q <= perf_dropped_q + 32'(filled_cnt) + 32'(rsp_expected);
      end else if (imem_rsp_valid && (drop_q != '0)) begin
        perf_dropped_q <= perf_dropped_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences and random
// traffic against a queue-based model of the fetch buffer, memory and program counter.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int DEPTH = 3;

  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, id_ready = 1'b0;
  logic [31:0] pc_in = '0, imem_rsp_data = '0;
  logic        pc_en, imem_req_valid, id_valid;
  logic [31:0] imem_req_addr, id_pc, id_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_dropped;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_en          (pc_en),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped)
`endif
  );

  typedef struct { logic [31:0] pc; bit arrived; } ent_t;
  typedef struct { logic [31:0] addr; int due; bit stale; } mem_t;
  typedef struct {
    bit flush; bit rr; bit ir;
    bit rv; logic [31:0] addr; bit pcen; bit idv; logic [31:0] idpc;
  } vec_t;

  ent_t        mq[$];    // allocated entries, oldest first
  mem_t        memq[$];  // requests in flight inside the memory
  int          cyc = 0, lat = 1, n_checks = 0, n_errors = 0;
  int          pops_m = 0, drops_m = 0;
  logic [31:0] pc_model = '0;
  bit          obs_rv, obs_pcen, obs_idv;
  logic [31:0] obs_addr, obs_idpc;
  vec_t        vecs[9];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit f, input logic [31:0] tgt, input bit rr,
                      input bit ir);
    bit   rsp, e_rv, e_acc, e_idv, e_pop;
    mem_t m;
    @(posedge clk);
    #1;
    cyc++;
    rst = r; flush = f; imem_req_ready = rr; id_ready = ir; pc_in = pc_model;
    rsp = !r && (memq.size() > 0) && (memq[0].due == cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? instr_of(memq[0].addr) : '0;
    @(negedge clk);
    e_rv  = !r && !f && (mq.size() < DEPTH);
    e_acc = e_rv && rr;
    e_idv = !r && (mq.size() > 0) && mq[0].arrived;
    e_pop = e_idv && ir && !f;
    obs_rv = imem_req_valid; obs_pcen = pc_en; obs_idv = id_valid;
    obs_addr = imem_req_addr; obs_idpc = id_pc;
    chk("req_valid", imem_req_valid, e_rv);
    chk("pc_en", pc_en, !r && (e_acc || f));
    chk("req_addr", imem_req_addr, pc_model & 32'hFFFF_FFFC);
    chk("id_valid", id_valid, e_idv);
    chk("id_pc", id_pc, e_idv ? mq[0].pc : 32'h0);
    chk("id_instr", id_instr, e_idv ? instr_of(mq[0].pc & 32'hFFFF_FFFC) : NOP_INSTR);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, r ? 0 : pops_m);
    chk("perf_dropped", perf_dropped, r ? 0 : drops_m);
`endif
    if (r) begin
      mq.delete(); memq.delete(); pc_model = '0; pops_m = 0; drops_m = 0;
    end else begin
      if (f) begin
        foreach (mq[i]) if (mq[i].arrived) drops_m++;
        mq.delete();
        foreach (memq[i]) memq[i].stale = 1'b1;
      end
      if (rsp) begin
        m = memq.pop_front();
        if (m.stale) drops_m++;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].arrived) begin mq[i].arrived = 1'b1; break; end
          end
        end
      end
      if (e_pop) begin void'(mq.pop_front()); pops_m++; end
      if (e_acc) begin
        mq.push_back('{pc: pc_model, arrived: 1'b0});
        memq.push_back('{addr: pc_model & 32'hFFFF_FFFC, due: cyc + lat, stale: 1'b0});
      end
      if (f) pc_model = tgt;
      else if (e_acc) pc_model = pc_model + 32'd4;
    end
  endtask

  task automatic wait_idv(input string name, input int bound);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      found = obs_idv;
    end
    if (!found) begin
      n_checks++; n_errors++;
      $display("FAIL %s: id_valid not seen within %0d cycles", name, bound);
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      done = (memq.size() == 0) && (mq.size() == 0);
    end
    chk("drain_done", done, 1);
  endtask

  initial begin
    logic [31:0] hold;
    //         flush rr ir  rv  addr    pcen idv idpc
    vecs[0] = '{0, 1, 1,  1, 32'd0,  1, 0, 32'd0};
    vecs[1] = '{0, 1, 1,  1, 32'd4,  1, 0, 32'd0};
    vecs[2] = '{0, 1, 0,  1, 32'd8,  1, 1, 32'd0};
    vecs[3] = '{0, 1, 0,  0, 32'd12, 0, 1, 32'd0};
    vecs[4] = '{0, 1, 0,  0, 32'd12, 0, 1, 32'd0};
    vecs[5] = '{0, 1, 1,  0, 32'd12, 0, 1, 32'd0};
    vecs[6] = '{0, 1, 1,  1, 32'd12, 1, 1, 32'd4};
    vecs[7] = '{0, 1, 1,  1, 32'd16, 1, 1, 32'd8};
    vecs[8] = '{0, 1, 1,  1, 32'd20, 1, 1, 32'd12};

    // Reset, start-up stream and decode backpressure at memory latency 1.
    lat = 1;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, vecs[i].flush, 32'h0, vecs[i].rr, vecs[i].ir);
      chk($sformatf("vec%0d_rv", i), obs_rv, vecs[i].rv);
      chk($sformatf("vec%0d_addr", i), obs_addr, vecs[i].addr);
      chk($sformatf("vec%0d_pcen", i), obs_pcen, vecs[i].pcen);
      chk($sformatf("vec%0d_idv", i), obs_idv, vecs[i].idv);
      chk($sformatf("vec%0d_idpc", i), obs_idpc, vecs[i].idpc);
    end

    // Memory stall: PC holds, addresses resume without a gap.
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    hold = pc_model & 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("stall_pcen", obs_pcen, 0);
      chk("stall_addr", obs_addr, hold);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("stall_resume_addr", obs_addr, hold);
    chk("stall_resume_rv", obs_rv, 1);

    // Flush with two requests in flight at latency 3.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    lat = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'hCAFE_BAB8, 1'b1, 1'b1);
    wait_idv("flush_first", 20);
    chk("flush_first_pc", obs_idpc, 32'hCAFE_BAB8);
    wait_idv("flush_second", 20);
    chk("flush_second_pc", obs_idpc, 32'hCAFE_BABC);
`ifdef FETCH_PERF_EN
    chk("perf_dropped_flush", perf_dropped, 2);
    chk("perf_fetched_flush", perf_fetched, 1);
`endif

    // Misaligned redirect target.
    drain();
    lat = 1;
    step(1'b0, 1'b1, 32'hCAFE_BABE, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("misaligned_addr", obs_addr, 32'hCAFE_BABC);
    chk("misaligned_rv", obs_rv, 1);
    wait_idv("misaligned", 20);
    chk("misaligned_idpc", obs_idpc, 32'hCAFE_BABE);

    // Back-to-back flushes coinciding with responses.
    drain();
    lat = 2;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
    wait_idv("b2b_flush", 20);
    chk("b2b_flush_pc", obs_idpc, 32'h300);

    // Reset in the middle of a stream.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    wait_idv("post_reset", 20);
    chk("post_reset_pc", obs_idpc, 32'h0);

    // Random traffic in latency segments.
    for (int seg = 0; seg < 8; seg++) begin
      drain();
      lat = $urandom_range(1, 4);
      for (int i = 0; i < 250; i++) begin
        logic [31:0] tgt;
        tgt = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 9) == 0) tgt = tgt | 32'h2;
        step(1'b0, $urandom_range(0, 99) < 4, tgt, $urandom_range(0, 99) < 75,
             $urandom_range(0, 99) < 70);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
